// File: rtl/ptp_rtc_frac.sv
// -----------------------------------------------------------------------------
// ptp_rtc_frac
//
// PTP real-time clock with a fractional-nanosecond accumulator.
// Internal time (seconds + nanoseconds + fraction) advances every clock by a
// programmable period. An optional slew adds a signed step per cycle for a
// programmable number of cycles. PTP time is internal time plus a signed
// offset, with carry/borrow into seconds, registered one stage later.
// A PPS pulse of PPS_LEN cycles starts on every seconds rollover.
//
// Configuration macro:
//   PTP_RTC_FRAC_SLEW_EN  defined   -> slew FSM and step adder present
//                         undefined -> i_adj_* ignored, o_adj_busy = 0
//
// Parameters:
//   SEC_W          width of seconds counters
//   FNS_W          fractional nanosecond bits
//   PERIOD_NS_RST  integer ns per cycle after reset (fraction resets to 0)
//   PPS_LEN        PPS high time in clk cycles
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_period_ld/_nsec/_frac           load per-cycle period (ns.frac)
//   i_time_ld/_sec/_nsec              direct internal time load
//   i_offset_ld/_nsec                 load signed PTP offset (ns)
//   i_adj_ld/_cnt/_nsec/_frac         start slew: cnt cycles of signed step
//   o_int_time_sec/_nsec/_frac        internal time
//   o_ptp_time_sec/_nsec              PTP time (internal + offset)
//   o_pps                             pulse-per-second
//   o_adj_busy                        slew in progress
// -----------------------------------------------------------------------------
module ptp_rtc_frac #(
    parameter int SEC_W         = 48,
    parameter int FNS_W         = 16,
    parameter int PERIOD_NS_RST = 8,
    parameter int PPS_LEN       = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_period_ld,
    input  logic [7:0]         i_period_nsec,
    input  logic [FNS_W-1:0]   i_period_frac,
    input  logic               i_time_ld,
    input  logic [SEC_W-1:0]   i_time_sec,
    input  logic [29:0]        i_time_nsec,
    input  logic               i_offset_ld,
    input  logic [31:0]        i_offset_nsec,
    input  logic               i_adj_ld,
    input  logic [7:0]         i_adj_cnt,
    input  logic [7:0]         i_adj_nsec,
    input  logic [FNS_W-1:0]   i_adj_frac,
    output logic [SEC_W-1:0]   o_int_time_sec,
    output logic [29:0]        o_int_time_nsec,
    output logic [FNS_W-1:0]   o_int_time_frac,
    output logic [SEC_W-1:0]   o_ptp_time_sec,
    output logic [29:0]        o_ptp_time_nsec,
    output logic               o_pps,
    output logic               o_adj_busy
);

    localparam int ACC_W = 30 + FNS_W;      // {nsec, frac}
    localparam int INC_W = 8 + FNS_W + 2;   // signed period + step, no overflow
    localparam int PPS_W = (PPS_LEN > 1) ? $clog2(PPS_LEN) : 1;

    // One second expressed in accumulator units (ns << FNS_W)
    localparam logic [ACC_W:0]     ROLL      = (ACC_W+1)'(1000000000) << FNS_W;
    localparam logic signed [32:0] NS_PER_S  = 33'sd1000000000;
    localparam logic [PPS_W-1:0]   PPS_RELOAD = PPS_W'(PPS_LEN - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [7+FNS_W:0]   r_period;
    logic [ACC_W-1:0]   r_acc;
    logic [SEC_W-1:0]   r_sec;
    logic [31:0]        r_offset;
    logic [SEC_W-1:0]   r_ptp_sec;
    logic [29:0]        r_ptp_nsec;
    logic               r_pps;
    logic [PPS_W-1:0]   r_pps_cnt;

    // ------------------------------------------------------------------
    // Slew step (optional)
    // ------------------------------------------------------------------
    logic signed [INC_W-1:0] w_step;
    logic                    w_busy;

`ifdef PTP_RTC_FRAC_SLEW_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SLEW = 1'b1;

    logic [0:0]         r_state;
    logic [7:0]         r_adj_cnt;
    logic [7+FNS_W:0]   r_adj_step;   // signed ns : unsigned frac, as one fixed-point word

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_adj_cnt  <= '0;
            r_adj_step <= '0;
        end else if (i_adj_ld && (i_adj_cnt != 8'd0)) begin
            // Starting or restarting: remaining count of an active slew is dropped
            r_state    <= ST_SLEW;
            r_adj_cnt  <= i_adj_cnt;
            r_adj_step <= {i_adj_nsec, i_adj_frac};
        end else if (r_state == ST_SLEW) begin
            // Counts down even on a time-load cycle
            r_adj_cnt <= r_adj_cnt - 8'd1;
            if (r_adj_cnt == 8'd1) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign w_busy = (r_state == ST_SLEW);
    assign w_step = w_busy ? {{2{r_adj_step[7+FNS_W]}}, r_adj_step} : '0;
`else
    logic w_adj_unused;
    assign w_adj_unused = ^{i_adj_ld, i_adj_cnt, i_adj_nsec, i_adj_frac};
    assign w_busy = 1'b0;
    assign w_step = '0;
`endif

    // ------------------------------------------------------------------
    // Increment and rollover
    // ------------------------------------------------------------------
    logic signed [INC_W-1:0] w_inc_s;
    logic [ACC_W:0]          w_inc;
    logic [ACC_W:0]          w_sum;
    logic [ACC_W:0]          w_sum_wrapped;
    logic                    w_roll;
    logic [ACC_W-1:0]        w_acc_next;
    logic                    w_acc_hi_unused;
    logic                    w_roll_evt;

    assign w_inc_s = $signed({2'b00, r_period}) + w_step;
    // A negative net increment would run time backwards; hold instead
    assign w_inc   = w_inc_s[INC_W-1] ? '0 : (ACC_W+1)'($unsigned(w_inc_s));
    assign w_sum   = {1'b0, r_acc} + w_inc;
    assign w_roll  = (w_sum >= ROLL);
    assign w_sum_wrapped = w_roll ? (w_sum - ROLL) : w_sum;
    assign {w_acc_hi_unused, w_acc_next} = w_sum_wrapped;
    // Only a rollover from counting is a real second boundary
    assign w_roll_evt = w_roll && !i_time_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= {8'(PERIOD_NS_RST), {FNS_W{1'b0}}};
        end else if (i_period_ld) begin
            r_period <= {i_period_nsec, i_period_frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_sec <= '0;
        end else if (i_time_ld) begin
            r_acc <= {i_time_nsec, {FNS_W{1'b0}}};
            r_sec <= i_time_sec;
        end else begin
            r_acc <= w_acc_next;
            if (w_roll) begin
                r_sec <= r_sec + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // PPS
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pps     <= 1'b0;
            r_pps_cnt <= '0;
        end else if (w_roll_evt) begin
            r_pps     <= 1'b1;
            r_pps_cnt <= PPS_RELOAD;
        end else if (r_pps_cnt != '0) begin
            r_pps_cnt <= r_pps_cnt - 1'b1;
        end else begin
            r_pps <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Offset and PTP time
    // ------------------------------------------------------------------
    logic signed [32:0] w_ptp_sum;
    logic signed [32:0] w_ptp_norm;
    logic [2:0]         w_ptp_hi_unused;
    logic [29:0]        w_ptp_nsec;
    logic [SEC_W-1:0]   w_ptp_sec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset <= '0;
        end else if (i_offset_ld) begin
            r_offset <= i_offset_nsec;
        end
    end

    // |offset| < 1e9 and nsec < 1e9, so one carry or borrow is enough
    assign w_ptp_sum = $signed({3'b000, r_acc[ACC_W-1:FNS_W]}) + $signed({r_offset[31], r_offset});

    always_comb begin
        w_ptp_norm = w_ptp_sum;
        w_ptp_sec  = r_sec;
        if (w_ptp_sum >= NS_PER_S) begin
            w_ptp_norm = w_ptp_sum - NS_PER_S;
            w_ptp_sec  = r_sec + 1'b1;
        end else if (w_ptp_sum < 0) begin
            w_ptp_norm = w_ptp_sum + NS_PER_S;
            w_ptp_sec  = r_sec - 1'b1;
        end
    end

    assign {w_ptp_hi_unused, w_ptp_nsec} = w_ptp_norm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptp_sec  <= '0;
            r_ptp_nsec <= '0;
        end else begin
            r_ptp_sec  <= w_ptp_sec;
            r_ptp_nsec <= w_ptp_nsec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign o_int_time_sec  = r_sec;
    assign o_int_time_nsec = r_acc[ACC_W-1:FNS_W];
    assign o_int_time_frac = r_acc[FNS_W-1:0];
    assign o_ptp_time_sec  = r_ptp_sec;
    assign o_ptp_time_nsec = r_ptp_nsec;
    assign o_pps           = r_pps;
    assign o_adj_busy      = w_busy;

endmodule

// File: tb/tb_ptp_rtc_frac.sv
// -----------------------------------------------------------------------------
// tb_ptp_rtc_frac: directed self-checking bench for ptp_rtc_frac
// (FNS_W=16, PPS_LEN=20). Slew scenarios expect the slew effect when
// PTP_RTC_FRAC_SLEW_EN is defined and no effect otherwise.
// -----------------------------------------------------------------------------
module tb_ptp_rtc_frac;

    logic        clk;
    logic        rst;
    logic        i_period_ld;
    logic [7:0]  i_period_nsec;
    logic [15:0] i_period_frac;
    logic        i_time_ld;
    logic [47:0] i_time_sec;
    logic [29:0] i_time_nsec;
    logic        i_offset_ld;
    logic [31:0] i_offset_nsec;
    logic        i_adj_ld;
    logic [7:0]  i_adj_cnt;
    logic [7:0]  i_adj_nsec;
    logic [15:0] i_adj_frac;
    logic [47:0] o_int_time_sec;
    logic [29:0] o_int_time_nsec;
    logic [15:0] o_int_time_frac;
    logic [47:0] o_ptp_time_sec;
    logic [29:0] o_ptp_time_nsec;
    logic        o_pps;
    logic        o_adj_busy;

    int n_checks = 0;
    int n_fail   = 0;

    ptp_rtc_frac #(
        .SEC_W(48), .FNS_W(16), .PERIOD_NS_RST(8), .PPS_LEN(20)
    ) dut (
        .clk(clk), .rst(rst),
        .i_period_ld(i_period_ld), .i_period_nsec(i_period_nsec), .i_period_frac(i_period_frac),
        .i_time_ld(i_time_ld), .i_time_sec(i_time_sec), .i_time_nsec(i_time_nsec),
        .i_offset_ld(i_offset_ld), .i_offset_nsec(i_offset_nsec),
        .i_adj_ld(i_adj_ld), .i_adj_cnt(i_adj_cnt), .i_adj_nsec(i_adj_nsec), .i_adj_frac(i_adj_frac),
        .o_int_time_sec(o_int_time_sec), .o_int_time_nsec(o_int_time_nsec),
        .o_int_time_frac(o_int_time_frac),
        .o_ptp_time_sec(o_ptp_time_sec), .o_ptp_time_nsec(o_ptp_time_nsec),
        .o_pps(o_pps), .o_adj_busy(o_adj_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_time(input logic [47:0] sec, input logic [29:0] ns);
        i_time_ld = 1'b1; i_time_sec = sec; i_time_nsec = ns;
        tick();
        i_time_ld = 1'b0;
    endtask

    task automatic test_reset();
        int pps_seen;
        rst = 1'b1;
        #2;
        n_checks++;
        if ({o_int_time_sec, o_int_time_nsec, o_int_time_frac, o_ptp_time_sec,
             o_ptp_time_nsec, o_pps, o_adj_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: int=%0d/%0d/%0h ptp=%0d/%0d pps=%b busy=%b, required all 0",
                     o_int_time_sec, o_int_time_nsec, o_int_time_frac, o_ptp_time_sec,
                     o_ptp_time_nsec, o_pps, o_adj_busy);
        end
        tick(); tick();
        rst = 1'b0;
        pps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_pps) pps_seen++;
        end
        n_checks++;
        if (o_int_time_nsec !== 30'd80 || o_int_time_sec !== 48'd0 || o_int_time_frac !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: int=%0d/%0d/%0h, required 0/80/0",
                     o_int_time_sec, o_int_time_nsec, o_int_time_frac);
        end
        n_checks++;
        if (o_ptp_time_nsec !== 30'd72 || o_ptp_time_sec !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_ptp_delay: ptp=%0d/%0d, required 0/72", o_ptp_time_sec, o_ptp_time_nsec);
        end
        n_checks++;
        if (pps_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_pps: pps high %0d cycles, required 0", pps_seen);
        end
        $display("test_reset: int=%0d/%0d ptp=%0d/%0d", o_int_time_sec, o_int_time_nsec,
                 o_ptp_time_sec, o_ptp_time_nsec);
    endtask

    task automatic test_rollover_pps();
        int pps_high;
        load_time(48'd5, 30'd999_999_992);
        n_checks++;
        if (o_int_time_sec !== 48'd5 || o_int_time_nsec !== 30'd999_999_992 || o_int_time_frac !== 16'd0) begin
            n_fail++;
            $display("FAIL time_load: int=%0d/%0d/%0h, required 5/999999992/0",
                     o_int_time_sec, o_int_time_nsec, o_int_time_frac);
        end
        n_checks++;
        if (o_pps !== 1'b0) begin
            n_fail++;
            $display("FAIL time_load_no_pps: pps=%b, required 0", o_pps);
        end
        tick();
        n_checks++;
        if (o_int_time_sec !== 48'd6 || o_int_time_nsec !== 30'd0 || o_pps !== 1'b1) begin
            n_fail++;
            $display("FAIL rollover: int=%0d/%0d pps=%b, required 6/0 pps=1",
                     o_int_time_sec, o_int_time_nsec, o_pps);
        end
        n_checks++;
        if (o_ptp_time_sec !== 48'd5 || o_ptp_time_nsec !== 30'd999_999_992) begin
            n_fail++;
            $display("FAIL rollover_ptp: ptp=%0d/%0d, required 5/999999992",
                     o_ptp_time_sec, o_ptp_time_nsec);
        end
        pps_high = o_pps ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_pps) pps_high++;
        end
        n_checks++;
        if (pps_high !== 20) begin
            n_fail++;
            $display("FAIL pps_length: high %0d cycles, required 20", pps_high);
        end
        $display("test_rollover_pps: pps high %0d cycles", pps_high);
    endtask

    task automatic test_frac_period();
        i_period_ld = 1'b1; i_period_nsec = 8'd6; i_period_frac = 16'h6666;
        load_time(48'd0, 30'd0);
        i_period_ld = 1'b0;
        n_checks++;
        if (o_int_time_nsec !== 30'd0 || o_int_time_frac !== 16'd0) begin
            n_fail++;
            $display("FAIL frac_load: int=%0d/%0h, required 0/0", o_int_time_nsec, o_int_time_frac);
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (o_int_time_nsec !== 30'd31 || o_int_time_frac !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL frac_accum: int=%0d/%0h, required 31/fffe", o_int_time_nsec, o_int_time_frac);
        end
        $display("test_frac_period: int=%0d.%0h", o_int_time_nsec, o_int_time_frac);
        i_period_ld = 1'b1; i_period_nsec = 8'd8; i_period_frac = 16'h0000;
        tick();
        i_period_ld = 1'b0;
    endtask

    task automatic test_offset();
        i_offset_ld = 1'b1; i_offset_nsec = 32'hFFFF_FFF6;   // -10
        load_time(48'd5, 30'd4);
        i_offset_ld = 1'b0;
        tick();
        n_checks++;
        if (o_ptp_time_sec !== 48'd4 || o_ptp_time_nsec !== 30'd999_999_994) begin
            n_fail++;
            $display("FAIL offset_borrow: ptp=%0d/%0d, required 4/999999994",
                     o_ptp_time_sec, o_ptp_time_nsec);
        end
        n_checks++;
        if (o_int_time_sec !== 48'd5 || o_int_time_nsec !== 30'd12) begin
            n_fail++;
            $display("FAIL offset_int: int=%0d/%0d, required 5/12", o_int_time_sec, o_int_time_nsec);
        end
        $display("test_offset: -10 -> ptp=%0d/%0d", o_ptp_time_sec, o_ptp_time_nsec);
        i_offset_ld = 1'b1; i_offset_nsec = 32'd10;
        load_time(48'd5, 30'd999_999_995);
        i_offset_ld = 1'b0;
        tick();
        n_checks++;
        if (o_ptp_time_sec !== 48'd6 || o_ptp_time_nsec !== 30'd5) begin
            n_fail++;
            $display("FAIL offset_carry: ptp=%0d/%0d, required 6/5", o_ptp_time_sec, o_ptp_time_nsec);
        end
        $display("test_offset: +10 -> ptp=%0d/%0d", o_ptp_time_sec, o_ptp_time_nsec);
        i_offset_ld = 1'b1; i_offset_nsec = 32'd0;
        tick();
        i_offset_ld = 1'b0;
    endtask

    // Slew of cnt cycles with integer step; returns busy cycles and final nsec
    task automatic run_slew(input logic [7:0] step, output int busy_cycles,
                            output int decreases);
        logic [29:0] prev;
        load_time(48'd0, 30'd0);
        i_adj_ld = 1'b1; i_adj_cnt = 8'd100; i_adj_nsec = step; i_adj_frac = 16'd0;
        tick();
        i_adj_ld = 1'b0;
        busy_cycles = o_adj_busy ? 1 : 0;
        decreases = 0;
        prev = o_int_time_nsec;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_adj_busy) busy_cycles++;
            if (o_int_time_nsec < prev) decreases++;
            prev = o_int_time_nsec;
        end
    endtask

    task automatic test_slew();
        int busy_cycles, decreases;
        int exp_busy;
        logic [29:0] exp_pos, exp_neg;
`ifdef PTP_RTC_FRAC_SLEW_EN
        exp_busy = 100; exp_pos = 30'd908; exp_neg = 30'd8;
`else
        exp_busy = 0;   exp_pos = 30'd808; exp_neg = 30'd808;
`endif
        run_slew(8'd1, busy_cycles, decreases);
        n_checks++;
        if (busy_cycles !== exp_busy) begin
            n_fail++;
            $display("FAIL slew_busy: busy %0d cycles, required %0d", busy_cycles, exp_busy);
        end
        n_checks++;
        if (o_int_time_nsec !== exp_pos || o_adj_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL slew_plus: int nsec=%0d busy=%b, required %0d busy=0",
                     o_int_time_nsec, o_adj_busy, exp_pos);
        end
        $display("test_slew: +1 step -> busy=%0d nsec=%0d", busy_cycles, o_int_time_nsec);
        run_slew(8'hF7, busy_cycles, decreases);   // -9 ns per cycle
        n_checks++;
        if (o_int_time_nsec !== exp_neg) begin
            n_fail++;
            $display("FAIL slew_clamp: int nsec=%0d, required %0d", o_int_time_nsec, exp_neg);
        end
        n_checks++;
        if (decreases !== 0) begin
            n_fail++;
            $display("FAIL slew_monotonic: %0d decreases, required 0", decreases);
        end
        $display("test_slew: -9 step -> busy=%0d nsec=%0d", busy_cycles, o_int_time_nsec);
    endtask

    task automatic test_reset_mid_slew();
        i_offset_ld = 1'b1; i_offset_nsec = 32'd5;
        load_time(48'd3, 30'd0);
        i_offset_ld = 1'b0;
        i_adj_ld = 1'b1; i_adj_cnt = 8'd100; i_adj_nsec = 8'd1; i_adj_frac = 16'd0;
        tick();
        i_adj_ld = 1'b0;
        for (int i = 0; i < 49; i++) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_int_time_sec, o_int_time_nsec, o_int_time_frac, o_ptp_time_sec,
             o_ptp_time_nsec, o_pps, o_adj_busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: int=%0d/%0d ptp=%0d/%0d pps=%b busy=%b, required all 0",
                     o_int_time_sec, o_int_time_nsec, o_ptp_time_sec, o_ptp_time_nsec,
                     o_pps, o_adj_busy);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (o_int_time_nsec !== 30'd24 || o_int_time_sec !== 48'd0 || o_adj_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_count: int=%0d/%0d busy=%b, required 0/24 busy=0",
                     o_int_time_sec, o_int_time_nsec, o_adj_busy);
        end
        n_checks++;
        if (o_ptp_time_nsec !== 30'd16) begin
            n_fail++;
            $display("FAIL post_reset_offset: ptp nsec=%0d, required 16", o_ptp_time_nsec);
        end
        $display("test_reset_mid_slew: int=%0d ptp=%0d", o_int_time_nsec, o_ptp_time_nsec);
    endtask

    initial begin
        rst = 1'b1;
        i_period_ld = 1'b0; i_period_nsec = 8'd8; i_period_frac = 16'd0;
        i_time_ld = 1'b0; i_time_sec = '0; i_time_nsec = '0;
        i_offset_ld = 1'b0; i_offset_nsec = '0;
        i_adj_ld = 1'b0; i_adj_cnt = '0; i_adj_nsec = '0; i_adj_frac = '0;
        test_reset();
        test_rollover_pps();
        test_frac_period();
        test_offset();
        test_slew();
        test_reset_mid_slew();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ptp_rtc_frac.md
# ptp_rtc_frac

Parametrised successor of the basic PTP real-time clock with a fractional-nanosecond accumulator. It keeps free-running internal time (seconds + nanoseconds + fraction) at a programmable per-cycle period, applies a slewed phase adjustment over a programmable number of cycles, and derives PTP time as internal time plus a signed offset. It sits between the PTP servo/CSR block and the timestamping units, and drives the board PPS pin.

## Interface
- `SEC_W`, default 48: width of the seconds counters.
- `FNS_W`, default 16: fractional-nanosecond bits in the accumulator.
- `PERIOD_NS_RST`, default 8: integer ns per cycle after reset (fraction resets to 0).
- `PPS_LEN`, default 20: PPS high duration, in clk cycles.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_period_ld` in 1: load the period.
- `i_period_nsec` in 8: integer ns per cycle.
- `i_period_frac` in FNS_W: fractional ns per cycle.
- `i_time_ld` in 1: direct time load.
- `i_time_sec` in SEC_W: seconds value to load.
- `i_time_nsec` in 30: ns value to load, 0..999_999_999.
- `i_offset_ld` in 1: load the offset register.
- `i_offset_nsec` in 32: signed offset, |value| < 1e9.
- `i_adj_ld` in 1: start a slew.
- `i_adj_cnt` in 8: number of slew cycles.
- `i_adj_nsec` in 8: signed integer ns step per slew cycle.
- `i_adj_frac` in FNS_W: fractional part of the step, unsigned and added to `i_adj_nsec`.
- `o_int_time_sec` out SEC_W: internal seconds.
- `o_int_time_nsec` out 30: internal ns.
- `o_int_time_frac` out FNS_W: internal fraction.
- `o_ptp_time_sec` out SEC_W: PTP seconds.
- `o_ptp_time_nsec` out 30: PTP ns.
- `o_pps` out 1: pulse-per-second.
- `o_adj_busy` out 1: slew in progress.

## Operation
- The accumulator is {nsec, frac}, which is 30+FNS_W bits. Every cycle the increment is inc = period + (slewing ? step : 0), computed signed. If inc < 0 it is clamped to 0, so time never runs backwards.
- Rollover: if acc + inc ≥ 1e9·2^FNS_W, then acc ← acc + inc − 1e9·2^FNS_W and sec ← sec + 1. Seconds wrap modulo 2^SEC_W. A single cycle never produces more than one rollover, because inc < 1e9.
- `i_time_ld` sets sec/nsec to the inputs, clears frac and suppresses the increment that cycle. It has priority over the increment, but the slew counter still decrements.
- `i_period_ld` latches the new period, which is used from the next cycle.
- `i_offset_ld` latches the offset. PTP time = int time + offset, with carry or borrow into seconds: nsec ≥ 1e9 subtracts 1e9 and increments sec; nsec < 0 adds 1e9 and decrements sec. The fraction is not part of PTP time.
- Slew FSM:
  - IDLE → SLEW on `i_adj_ld` with `i_adj_cnt` ≠ 0. The step and count are latched.
  - SLEW: count decrements every cycle and the step is added while count > 0. At count = 1 the FSM returns to IDLE.
  - `i_adj_ld` during SLEW restarts the slew with the new values, discarding the remaining count.
  - `i_adj_cnt` = 0 is ignored.
- PPS: on the cycle the seconds increment by rollover, `o_pps` goes high for PPS_LEN cycles. A new rollover during a pulse restarts the length counter. Seconds changed by `i_time_ld` or by offset carry do not generate PPS.

## Timing
- All outputs are registered. On reset every output is 0, the period is PERIOD_NS_RST.0, the offset is 0 and the FSM is IDLE.
- Internal time: a load or increment applied in cycle N is visible at N+1.
- PTP time is one further register stage, so an internal value at N+1 appears as PTP time at N+2. An offset load at N is reflected in PTP time at N+2.
- `o_pps` rises in the same cycle that `o_int_time_sec` shows the incremented value.
- `o_adj_busy` is high from the cycle after `i_adj_ld` for exactly `i_adj_cnt` cycles.
- Simultaneous loads in one cycle are all accepted independently.
- `rst` asserted mid-slew or mid-pulse clears everything immediately (asynchronously).

## Configuration
- `PTP_RTC_FRAC_SLEW_EN` defined: the slew FSM and step adder are present, as described above.
- `PTP_RTC_FRAC_SLEW_EN` undefined:
  - The `i_adj_*` inputs are ignored and `o_adj_busy` is tied to 0.
  - The increment is always the period.
  - All other behaviour is identical.

## Test plan
All scenarios use FNS_W=16 and PPS_LEN=20.

- Reset, then run 10 cycles with period 8.0 → int nsec = 80; PTP time equals int time delayed by one cycle; `o_pps` stays 0.
- Load time sec=5, nsec=999_999_992 → the next cycle shows 5/999_999_992, the cycle after shows 6/0 with `o_pps` high for exactly 20 cycles.
- Load period 6.4 ns (frac 0x6666) after a time load of 0/0 → after 5 increments nsec = 31 and frac = 0xFFFE.
- Set offset −10 with int at 5/4 → PTP = 4/999_999_994. Set offset +10 with int at 5/999_999_995 → PTP = 6/5.
- Slew cnt=100, step +1.0 at period 8 → busy for 100 cycles, int is 100 ns ahead of the unadjusted count. Repeat with step −9 → time holds, no decrease. Repeat with the macro undefined → no effect.
- Assert `rst` mid-slew at cycle 50 → all outputs 0 and busy 0 immediately; after release, time counts from 0 at 8 ns per cycle.
